// File: rtl/alu_decode.sv
// Pipelined MIPS64 decoder feeding the ALU: one-cycle registered decode with a
// two-entry output/skid pair so EX backpressure never inserts bubbles.
module alu_decode #(
  parameter int WIDTH = 64
) (
  input  logic             p_clk,
  input  logic             p_rst_n,
  input  logic             p_flush,
  input  logic             p_in_valid,
  output logic             p_in_ready,
  input  logic [31:0]      p_instr,
  output logic             p_out_valid,
  input  logic             p_out_ready,
  output logic [3:0]       p_ALUop,
  output logic [4:0]       p_SHAMT,
  output logic             p_a_sel,
  output logic             p_b_sel,
  output logic [WIDTH-1:0] p_imm,
  output logic [4:0]       p_rs,
  output logic [4:0]       p_rt,
  output logic [4:0]       p_rd,
  output logic             p_reg_wr,
  output logic             p_illegal
);

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_DADDI  = 6'h18;
  localparam logic [5:0] OP_DADDIU = 6'h19;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  localparam logic [5:0] F_DADD  = 6'h2C;
  localparam logic [5:0] F_DADDU = 6'h2D;
  localparam logic [5:0] F_DSUB  = 6'h2E;
  localparam logic [5:0] F_DSUBU = 6'h2F;

  typedef struct packed {
    logic [3:0]       aluop;
    logic [4:0]       shamt;
    logic             a_sel;
    logic             b_sel;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic             reg_wr;
    logic             illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic bundle_t decode(input logic [31:0] instr);
    bundle_t          b;
    logic             legal;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] sext;
    logic [WIDTH-1:0] zext;
    op    = instr[31:26];
    funct = instr[5:0];
    sext  = {{(WIDTH-16){instr[15]}}, instr[15:0]};
    zext  = {{(WIDTH-16){1'b0}}, instr[15:0]};
    b     = '0;
    legal = 1'b1;
    b.rs  = instr[25:21];
    b.rt  = instr[20:16];
    b.rd  = instr[15:11];
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD, F_DADD:   b.aluop = 4'b0100;
        F_ADDU, F_DADDU: b.aluop = 4'b0101;
        F_SUB, F_DSUB:   b.aluop = 4'b0110;
        F_SUBU, F_DSUBU: b.aluop = 4'b0111;
        F_AND:           b.aluop = 4'b0000;
        F_OR:            b.aluop = 4'b0001;
        F_XOR:           b.aluop = 4'b0010;
        F_NOR:           b.aluop = 4'b0011;
        F_SLT:           b.aluop = 4'b1010;
        F_SLTU:          b.aluop = 4'b1011;
        F_SLL, F_SRL, F_SRA: begin
          b.aluop = (funct == F_SLL) ? 4'b1100 :
                    (funct == F_SRL) ? 4'b1110 : 4'b1111;
          b.a_sel = 1'b1;
          b.shamt = instr[10:6];
        end
        default:         legal = 1'b0;
      endcase
    end else begin
      // I-type writes rt, so the destination index is steered onto rd
      b.b_sel = 1'b1;
      b.rd    = instr[20:16];
      case (op)
        OP_ADDI, OP_DADDI: begin
          b.aluop = 4'b0100;
          b.imm   = sext;
        end
        OP_ADDIU, OP_DADDIU: begin
          b.aluop = 4'b0101;
          b.imm   = sext;
        end
        OP_SLTI: begin
          b.aluop = 4'b1010;
          b.imm   = sext;
        end
        OP_SLTIU: begin
          b.aluop = 4'b1011;
          b.imm   = sext;
        end
        OP_ANDI: begin
          b.aluop = 4'b0000;
          b.imm   = zext;
        end
        OP_ORI: begin
          b.aluop = 4'b0001;
          b.imm   = zext;
        end
        OP_XORI: begin
          b.aluop = 4'b0010;
          b.imm   = zext;
        end
        default: legal = 1'b0;
      endcase
    end
    // Illegal words still travel down the pipe, with raw register fields
    if (!legal) begin
      b.aluop = 4'b0000;
      b.shamt = 5'd0;
      b.a_sel = 1'b0;
      b.b_sel = 1'b0;
      b.imm   = '0;
      b.rd    = instr[15:11];
    end
    b.illegal = ~legal;
    b.reg_wr  = legal && (b.rd != 5'd0);
    return b;
  endfunction

  state_t  state;
  bundle_t out_q;
  bundle_t skid_q;
  bundle_t dec;
  logic    in_ready_q;
  logic    out_valid_q;
  logic    accept;
  logic    drain;

  assign dec    = decode(p_instr);
  assign accept = p_in_valid && in_ready_q;
  assign drain  = out_valid_q && p_out_ready;

  // Occupancy FSM: out_q is the visible head, skid_q catches one extra bundle
  // while EX stalls; ready and valid are registered images of the next state.
  always_ff @(posedge p_clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      state       <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (p_flush) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_q       <= dec;
            state       <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !drain) begin
            skid_q     <= dec;
            state      <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (drain && !accept) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end else if (accept && drain) begin
            out_q <= dec;
          end
        end
        ST_TWO: begin
          if (drain) begin
            out_q      <= skid_q;
            state      <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign p_in_ready  = in_ready_q;
  assign p_out_valid = out_valid_q;
  assign p_ALUop     = out_q.aluop;
  assign p_SHAMT     = out_q.shamt;
  assign p_a_sel     = out_q.a_sel;
  assign p_b_sel     = out_q.b_sel;
  assign p_imm       = out_q.imm;
  assign p_rs        = out_q.rs;
  assign p_rt        = out_q.rt;
  assign p_rd        = out_q.rd;
  assign p_reg_wr    = out_q.reg_wr;
  assign p_illegal   = out_q.illegal;

endmodule
